// File: rtl/hamming_tx_ctrl.sv
// Serial extended-Hamming (16,11) SECDED frame sequencer: builds the frame one
// position per clock, appends parity, then streams it under back-pressure.
module hamming_tx_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        dataout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] codeword,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, PARITY, SEND} state_t;

  state_t      state_q;
  logic [3:0]  pos_q;
  logic [3:0]  beat_q;
  logic [10:0] data_q;
  logic [15:0] frame_q;
  logic [3:0]  par_q;
  logic        din_ready_q;
  logic        dout_valid_q;
  logic        dataout_q;
  logic        frame_start_q;
  logic        frame_end_q;
  logic [15:0] codeword_q;
  logic        busy_q;

  logic        is_par_pos;
  logic        p0;
  logic [15:0] full_frame_d;

  function automatic logic pick(input logic [15:0] f, input logic [3:0] b);
    pick = MSB_FIRST ? f[4'd15 - b] : f[b];
  endfunction

  // par_q[k] is the accumulator for parity bit p(2^k).
  always_comb begin
    is_par_pos   = ((pos_q & (pos_q - 4'd1)) == 4'd0);
    p0           = (^frame_q) ^ (^par_q);
    full_frame_d = frame_q | {7'b0, par_q[3], 3'b0, par_q[2], 1'b0, par_q[1], par_q[0], p0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pos_q         <= '0;
      beat_q        <= '0;
      data_q        <= '0;
      frame_q       <= '0;
      par_q         <= '0;
      din_ready_q   <= 1'b0;
      dout_valid_q  <= 1'b0;
      dataout_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      codeword_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          din_ready_q <= 1'b1;
          if (din_valid && din_ready_q) begin
            data_q      <= din;
            frame_q     <= '0;
            par_q       <= '0;
            pos_q       <= 4'd1;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (is_par_pos) begin
            frame_q[pos_q] <= 1'b0;
          end else begin
            frame_q[pos_q] <= data_q[0];
            data_q         <= data_q >> 1;
            par_q          <= par_q ^ (pos_q & {4{data_q[0]}});
          end
          if (pos_q == 4'd15) begin
            state_q <= PARITY;
          end else begin
            pos_q <= pos_q + 4'd1;
          end
        end
        PARITY: begin
          frame_q       <= full_frame_d;
          codeword_q    <= full_frame_d;
          beat_q        <= '0;
          dout_valid_q  <= 1'b1;
          dataout_q     <= pick(full_frame_d, 4'd0);
          frame_start_q <= 1'b1;
          frame_end_q   <= 1'b0;
          state_q       <= SEND;
        end
        SEND: begin
          // Outputs are precomputed for the beat that follows the handshake.
          if (dout_ready) begin
            if (beat_q == 4'd15) begin
              dout_valid_q  <= 1'b0;
              dataout_q     <= 1'b0;
              frame_start_q <= 1'b0;
              frame_end_q   <= 1'b0;
              busy_q        <= 1'b0;
              din_ready_q   <= 1'b1;
              state_q       <= IDLE;
            end else begin
              beat_q        <= beat_q + 4'd1;
              dataout_q     <= pick(frame_q, beat_q + 4'd1);
              frame_start_q <= 1'b0;
              frame_end_q   <= (beat_q == 4'd14);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din_ready   = din_ready_q;
  assign dout_valid  = dout_valid_q;
  assign dataout     = dataout_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign codeword    = codeword_q;
  assign busy        = busy_q;

endmodule
